// File: rtl/enc8to3_seq_if.sv
// Handshake bundle for enc8to3_seq: the request side drives load/req/ready,
// the encoder returns the index stream and its status flags.
interface enc8to3_seq_if;
  logic       load;
  logic [7:0] req;
  logic       ready;
  logic [2:0] y;
  logic       valid;
  logic       busy;
  logic       done;
  logic [7:0] pending;

  modport master (
    output load, req, ready,
    input  y, valid, busy, done, pending
  );

  modport slave (
    input  load, req, ready,
    output y, valid, busy, done, pending
  );
endinterface

// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 request encoder. Captures an 8-bit request mask in IDLE
// and offers one 3-bit index per accepted handshake, clearing each served bit.
// Default selection is fixed priority, highest index first.
// Optional macro ENC8TO3_ROUND_ROBIN_EN: selection searches downward from
// (ptr - 1) mod 8, where ptr tracks the last accepted index across batches.
module enc8to3_seq (
  input  logic         clk,
  input  logic         rst_n,
  enc8to3_seq_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e     state_q;
  logic [2:0] y_q;
  logic       valid_q;
  logic       done_q;
  logic [7:0] pending_q;

  logic [7:0] remaining;
  logic [2:0] idle_start;
  logic [2:0] serve_start;

`ifdef ENC8TO3_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
`endif

  // Downward search starting at 'start', wrapping 7 after 0. The i=0 pass
  // runs last so the index closest to 'start' wins.
  function automatic logic [2:0] pick(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    pick = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start - 3'(i);
      if (mask[idx]) pick = idx;
    end
  endfunction

  // Mask left after the current index is accepted, and the search origins.
  always_comb begin
    remaining = pending_q & ~(8'd1 << y_q);
`ifdef ENC8TO3_ROUND_ROBIN_EN
    idle_start  = ptr_q - 3'd1;
    // ptr takes y_q on this accept, so the next search starts just below it
    serve_start = y_q - 3'd1;
`else
    idle_start  = 3'd7;
    serve_start = 3'd7;
`endif
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      y_q       <= 3'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 8'h00;
`ifdef ENC8TO3_ROUND_ROBIN_EN
      ptr_q     <= 3'd0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load && (bus.req != 8'h00)) begin
            pending_q <= bus.req;
            y_q       <= pick(bus.req, idle_start);
            valid_q   <= 1'b1;
            state_q   <= StServe;
          end
        end
        StServe: begin
          // load is deliberately ignored here; the batch runs to completion
          if (bus.ready) begin
            pending_q <= remaining;
`ifdef ENC8TO3_ROUND_ROBIN_EN
            ptr_q     <= y_q;
`endif
            if (remaining != 8'h00) begin
              y_q <= pick(remaining, serve_start);
            end else begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.y       = y_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = (state_q == StServe);
  assign bus.done    = done_q;
  assign bus.pending = pending_q;

endmodule
